// File: rtl/danger_spawner.sv
// danger_spawner: owns the three on-screen obstacle slots. Spawns cactus/bird
// obstacles at pseudo-random gaps, scrolls them left on every move tick and
// retires them once they have scrolled past x=0. All outputs are registered.
module danger_spawner #(
    parameter int          SPAWN_X   = 700,
    parameter int          MIN_GAP   = 40,
    parameter int          INIT_GAP  = 60,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] game_state,
    input  logic       move_tick,
    input  logic [3:0] speed,
    input  logic       bird_en,
    output logic [9:0] danger_pos1,
    output logic [9:0] danger_pos2,
    output logic [9:0] danger_pos3,
    output logic [2:0] danger_type1,
    output logic [2:0] danger_type2,
    output logic [2:0] danger_type3,
    output logic       danger_en1,
    output logic       danger_en2,
    output logic       danger_en3
);

    typedef enum logic [1:0] {
        GS_INIT  = 2'd0,
        GS_START = 2'd1,
        GS_END   = 2'd2,
        GS_RESET = 2'd3
    } game_state_t;

    localparam logic [9:0]  SPAWN_POS    = 10'(SPAWN_X);
    localparam logic [7:0]  MIN_GAP_B    = 8'(MIN_GAP);
    localparam logic [7:0]  INIT_GAP_B   = 8'(INIT_GAP);
    localparam logic [2:0]  TYPE_NOTHING = 3'd5;
    localparam logic [15:0] LFSR_MASK    = 16'hB400;

    game_state_t gs;
    logic [15:0] lfsr_reg;
    logic [15:0] lfsr_next;
    logic [7:0]  gap_reg;
    logic        clear_all;
    logic        step;
    logic [2:0]  en_all;
    logic [2:0]  free;
    logic        spawn_go;
    logic [2:0]  spawn_sel;
    logic [2:0]  spawn_type;
    logic [9:0]  speed_ext;
    logic [9:0]  pos_all  [3];
    logic [2:0]  type_all [3];

    assign gs        = game_state_t'(game_state);
    assign clear_all = (gs == GS_INIT) || (gs == GS_RESET);
    assign step      = (gs == GS_START) && move_tick;
    assign speed_ext = {6'd0, speed};

    // Slots are judged free on their pre-tick enable, so a slot retiring on
    // this tick only becomes available on the next one.
    assign free      = ~en_all;
    assign spawn_go  = step && (gap_reg == 8'd0) && (|free);

    // Galois LFSR, right-shifting; free-runs in every game state
    assign lfsr_next = {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? LFSR_MASK : 16'h0000);

    // LFSR state register
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_reg <= LFSR_SEED;
        end else begin
            lfsr_reg <= lfsr_next;
        end
    end

    // Lowest-index free slot receives the spawn
    always_comb begin
        spawn_sel = 3'b000;
        if (spawn_go) begin
            if (free[0]) begin
                spawn_sel = 3'b001;
            end else if (free[1]) begin
                spawn_sel = 3'b010;
            end else begin
                spawn_sel = 3'b100;
            end
        end
    end

    // Obstacle type: fold 5..7 onto cactus types, push birds to cacti when disabled
    always_comb begin
        spawn_type = lfsr_reg[2:0];
        if (spawn_type >= 3'd5) begin
            spawn_type = spawn_type - 3'd3;
        end
        if (!bird_en && (spawn_type < 3'd2)) begin
            spawn_type = spawn_type + 3'd2;
        end
    end

    // Gap counter: counts ticks down to the next spawn, sticks at 0 while all slots are busy
    always_ff @(posedge clk) begin
        if (rst || clear_all) begin
            gap_reg <= INIT_GAP_B;
        end else if (step) begin
            if (gap_reg != 8'd0) begin
                gap_reg <= gap_reg - 8'd1;
            end else if (|free) begin
                gap_reg <= MIN_GAP_B + {2'b00, lfsr_reg[15:10]};
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_slot
            logic [9:0] pos_reg;
            logic [2:0] type_reg;
            logic       en_reg;

            // Per-slot scroll / retire / spawn register
            always_ff @(posedge clk) begin
                if (rst || clear_all) begin
                    en_reg   <= 1'b0;
                    pos_reg  <= 10'd0;
                    type_reg <= TYPE_NOTHING;
                end else if (step) begin
                    if (en_reg) begin
                        if (pos_reg < speed_ext) begin
                            en_reg   <= 1'b0;
                            pos_reg  <= 10'd0;
                            type_reg <= TYPE_NOTHING;
                        end else begin
                            pos_reg <= pos_reg - speed_ext;
                        end
                    end else if (spawn_sel[gi]) begin
                        en_reg   <= 1'b1;
                        pos_reg  <= SPAWN_POS;
                        type_reg <= spawn_type;
                    end
                end
            end

            assign en_all[gi]   = en_reg;
            assign pos_all[gi]  = pos_reg;
            assign type_all[gi] = type_reg;
        end
    endgenerate

    assign danger_en1   = en_all[0];
    assign danger_en2   = en_all[1];
    assign danger_en3   = en_all[2];
    assign danger_pos1  = pos_all[0];
    assign danger_pos2  = pos_all[1];
    assign danger_pos3  = pos_all[2];
    assign danger_type1 = type_all[0];
    assign danger_type2 = type_all[1];
    assign danger_type3 = type_all[2];

endmodule

// File: tb/tb_danger_spawner.sv
// tb_danger_spawner: random and directed stimulus for danger_spawner, checked
// every cycle against a behavioural model of the obstacle slots.
module tb_danger_spawner;

    localparam int          SPAWN_X   = 700;
    localparam int          MIN_GAP   = 4;
    localparam int          INIT_GAP  = 60;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] game_state;
    logic       move_tick;
    logic [3:0] speed;
    logic       bird_en;
    logic [9:0] danger_pos1, danger_pos2, danger_pos3;
    logic [2:0] danger_type1, danger_type2, danger_type3;
    logic       danger_en1, danger_en2, danger_en3;

    danger_spawner #(
        .SPAWN_X  (SPAWN_X),
        .MIN_GAP  (MIN_GAP),
        .INIT_GAP (INIT_GAP),
        .LFSR_SEED(LFSR_SEED)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .game_state  (game_state),
        .move_tick   (move_tick),
        .speed       (speed),
        .bird_en     (bird_en),
        .danger_pos1 (danger_pos1),
        .danger_pos2 (danger_pos2),
        .danger_pos3 (danger_pos3),
        .danger_type1(danger_type1),
        .danger_type2(danger_type2),
        .danger_type3(danger_type3),
        .danger_en1  (danger_en1),
        .danger_en2  (danger_en2),
        .danger_en3  (danger_en3)
    );

    always #5 clk = ~clk;

    // Reference model state
    int          m_en   [3];
    int          m_pos  [3];
    int          m_type [3];
    int          m_gap;
    logic [15:0] m_lfsr;

    int total = 0;
    int bad   = 0;

    // Spawn observation
    int        prev_en [3] = '{0, 0, 0};
    int        spawns_nobird = 0;
    logic [4:0] mask_nobird = 5'd0;
    logic [4:0] mask_bird   = 5'd0;
    bit        phase_nobird = 1'b0;

    task automatic finish_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int pick_type(input logic [15:0] l, input logic be);
        int tbl [8];
        int t;
        tbl = '{0, 1, 2, 3, 4, 2, 3, 4};
        t = tbl[int'(l & 16'h7)];
        if (!be && t < 2) t = t + 2;
        return t;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            m_en[i] = 0; m_pos[i] = 0; m_type[i] = 5;
        end
        m_gap = INIT_GAP;
    endtask

    // Advance the model by one clock using the inputs currently applied
    task automatic model_step();
        logic [15:0] l;
        int free_idx;
        if (rst) begin
            model_clear();
            m_lfsr = LFSR_SEED;
            return;
        end
        l = m_lfsr;
        m_lfsr = (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
        if (game_state == 2'd0 || game_state == 2'd3) begin
            model_clear();
        end else if (game_state == 2'd1 && move_tick) begin
            free_idx = -1;
            for (int i = 0; i < 3; i++)
                if (m_en[i] == 0 && free_idx < 0) free_idx = i;
            for (int i = 0; i < 3; i++) begin
                if (m_en[i] != 0) begin
                    if (m_pos[i] < int'(speed)) begin
                        m_en[i] = 0; m_pos[i] = 0; m_type[i] = 5;
                    end else begin
                        m_pos[i] = m_pos[i] - int'(speed);
                    end
                end
            end
            if (m_gap > 0) begin
                m_gap = m_gap - 1;
            end else if (free_idx >= 0) begin
                m_en[free_idx]   = 1;
                m_pos[free_idx]  = SPAWN_X;
                m_type[free_idx] = pick_type(l, bird_en);
                m_gap = MIN_GAP + int'(l >> 10);
            end
        end
    endtask

    function automatic logic [41:0] model_vec();
        logic [41:0] v;
        v = '0;
        for (int i = 0; i < 3; i++)
            v[i*14 +: 14] = {m_en[i] != 0, 10'(m_pos[i]), 3'(m_type[i])};
        return v;
    endfunction

    function automatic logic [41:0] dut_vec();
        return {danger_en3, danger_pos3, danger_type3,
                danger_en2, danger_pos2, danger_type2,
                danger_en1, danger_pos1, danger_type1};
    endfunction

    // One clock: update model, let DUT clock, compare on the falling edge
    task automatic do_cycle();
        int en_now [3];
        int ty_now [3];
        model_step();
        @(posedge clk);
        @(negedge clk);
        chk("slots", {22'd0, dut_vec()}, {22'd0, model_vec()});
        en_now = '{int'(danger_en1), int'(danger_en2), int'(danger_en3)};
        ty_now = '{int'(danger_type1), int'(danger_type2), int'(danger_type3)};
        for (int i = 0; i < 3; i++) begin
            if (en_now[i] != 0 && prev_en[i] == 0 && ty_now[i] < 5) begin
                if (phase_nobird) begin
                    spawns_nobird++;
                    mask_nobird[ty_now[i]] = 1'b1;
                end else begin
                    mask_bird[ty_now[i]] = 1'b1;
                end
            end
            prev_en[i] = en_now[i];
        end
        if (bad >= 20) finish_run();
    endtask

    task automatic drive(input logic r, input logic [1:0] gs, input logic tk,
                         input logic [3:0] spd, input logic be);
        rst = r; game_state = gs; move_tick = tk; speed = spd; bird_en = be;
        do_cycle();
    endtask

    initial begin
        int cyc;
        int end_left;
        int active;
        logic [41:0] snap;

        rst = 1'b1; game_state = 2'd0; move_tick = 1'b0; speed = 4'd0; bird_en = 1'b1;

        // Reset for two cycles
        drive(1, 2'd0, 0, 0, 1);
        drive(1, 2'd0, 1, 5, 1);
        chk("reset_en", {61'd0, danger_en3, danger_en2, danger_en1}, 64'd0);
        chk("reset_type", {55'd0, danger_type3, danger_type2, danger_type1}, {55'd0, 3'd5, 3'd5, 3'd5});

        // INIT with 100 ticks: nothing moves
        for (int i = 0; i < 200; i++) drive(0, 2'd0, 1'(i % 2), 4'd5, 1);
        chk("init_idle", {61'd0, danger_en3, danger_en2, danger_en1}, 64'd0);

        // START: first spawn lands on the 61st tick
        for (int i = 1; i <= 60; i++) drive(0, 2'd1, 1, 4'd5, 1);
        chk("no_spawn_60", {63'd0, danger_en1}, 64'd0);
        drive(0, 2'd1, 1, 4'd5, 1);
        chk("first_spawn", {53'd0, danger_en1, danger_pos1}, {53'd0, 1'b1, 10'd700});
        for (int i = 0; i < 10; i++) drive(0, 2'd1, 1, 4'd5, 1);
        chk("scroll_650", {54'd0, danger_pos1}, 64'd650);

        // Frozen scroll: slots fill up and the gap counter sticks at 0
        for (int i = 0; i < 250; i++) drive(0, 2'd1, 1, 4'd0, 1);
        chk("all_full", {61'd0, danger_en3, danger_en2, danger_en1}, 64'd7);
        // Fast scroll retires them and refills
        for (int i = 0; i < 150; i++) drive(0, 2'd1, 1, 4'd15, 1);

        // Random run with birds disabled, occasional END pauses
        phase_nobird = 1'b1;
        cyc = 0; end_left = 0;
        while (spawns_nobird < 500 && cyc < 40000) begin
            if (cyc % 16 == 0) speed = 4'($urandom_range(1, 15));
            if (end_left == 0 && $urandom_range(0, 199) == 0) end_left = 30;
            drive(0, end_left > 0 ? 2'd2 : 2'd1, 1'($urandom_range(0, 3) != 0), speed, 0);
            if (end_left > 0) end_left--;
            cyc++;
        end
        phase_nobird = 1'b0;
        chk("nobird_spawns", 64'(spawns_nobird >= 500), 64'd1);
        chk("no_bird_types", {59'd0, mask_nobird & 5'b00011}, 64'd0);

        // Random run with birds enabled until all five types are seen
        cyc = 0;
        while (mask_bird != 5'h1F && cyc < 20000) begin
            if (cyc % 16 == 0) speed = 4'($urandom_range(0, 15));
            drive(0, 2'd1, 1'($urandom(0) % 2 == 0 ? 1 : $urandom_range(0, 1)), speed, 1);
            cyc++;
        end
        chk("all_types", {59'd0, mask_bird}, 64'h1F);

        // END freeze with two active obstacles
        drive(0, 2'd0, 0, 4'd3, 1);
        cyc = 0;
        active = 0;
        while (active < 2 && cyc < 2000) begin
            drive(0, 2'd1, 1, 4'd1, 1);
            active = int'(danger_en1) + int'(danger_en2) + int'(danger_en3);
            cyc++;
        end
        chk("two_active", 64'(active >= 2), 64'd1);
        snap = model_vec();
        for (int i = 0; i < 50; i++) drive(0, 2'd2, 1, 4'd9, 1);
        chk("end_frozen", {22'd0, dut_vec()}, {22'd0, snap});

        // RESET state clears on the next cycle; gap reloads to INIT_GAP
        drive(0, 2'd3, 1, 4'd9, 1);
        chk("reset_state_clr", {61'd0, danger_en3, danger_en2, danger_en1}, 64'd0);
        for (int i = 1; i <= 60; i++) drive(0, 2'd1, 1, 4'd2, 1);
        chk("regap_none", {63'd0, danger_en1}, 64'd0);
        drive(0, 2'd1, 1, 4'd2, 1);
        chk("regap_spawn", {53'd0, danger_en1, danger_pos1}, {53'd0, 1'b1, 10'd700});

        // Reset asserted during a tick wins
        for (int i = 0; i < 30; i++) drive(0, 2'd1, 1, 4'd2, 1);
        drive(1, 2'd1, 1, 4'd2, 1);
        chk("rst_mid_tick", {61'd0, danger_en3, danger_en2, danger_en1}, 64'd0);
        for (int i = 0; i < 100; i++) drive(0, 2'd1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1);

        finish_run();
    end

endmodule
